// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - captures N diagonal result vectors on first-finish
// and drains them one element per beat on an AXI-Stream master port.
module systolic_result_collector #(
  parameter int SIZE     = 32,
  parameter int O_BITS   = 16,
  localparam int IDX_BITS = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [2:0]               rf_matrix_size,
  input  logic                     i_first_finish,
  input  logic [SIZE*O_BITS-1:0]   i_c_diag,
  output logic [O_BITS-1:0]        o_tdata,
  output logic                     o_tvalid,
  input  logic                     i_tready,
  output logic                     o_tlast,
  output logic [2*IDX_BITS-1:0]    o_tuser,
  output logic                     o_busy,
  output logic                     o_overrun,
  input  logic                     i_clear_overrun
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t                state;
  logic                  ff_prev;
  logic [IDX_BITS-1:0]   n_last;
  logic [IDX_BITS-1:0]   t_cnt;
  logic [IDX_BITS-1:0]   k_cnt;
  logic [SIZE*O_BITS-1:0] buf_mem [SIZE];

  logic                  trigger;
  logic [IDX_BITS-1:0]   n_last_next;
  logic                  wr_en;
  logic [IDX_BITS-1:0]   wr_addr;
  logic [SIZE*O_BITS-1:0] rd_word;
  logic                  drain_last;
  logic [31:0]           n_pow;

  assign trigger = i_first_finish && !ff_prev;

  // Active size is a power of two from the size code, clamped to the physical array.
  always_comb begin
    n_pow = 32'd1 << rf_matrix_size;
    if (n_pow > 32'(SIZE)) n_pow = 32'(SIZE);
    n_last_next = IDX_BITS'(n_pow - 32'd1);
  end

  assign wr_en   = (state == CAPTURE) || ((state == IDLE) && trigger);
  assign wr_addr = (state == CAPTURE) ? t_cnt : '0;

  // Result buffer carries no reset; it is fully rewritten before every drain.
  always_ff @(posedge i_clock) begin
    if (wr_en) buf_mem[wr_addr] <= i_c_diag;
  end

  assign rd_word    = buf_mem[t_cnt];
  assign drain_last = (t_cnt == n_last) && (k_cnt == n_last);

  assign o_tvalid = (state == DRAIN);
  assign o_tdata  = o_tvalid ? rd_word[int'(k_cnt)*O_BITS +: O_BITS] : '0;
  assign o_tuser  = o_tvalid ? {k_cnt, t_cnt} : '0;
  assign o_tlast  = o_tvalid && drain_last;
  assign o_busy   = (state != IDLE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      ff_prev   <= 1'b0;
      n_last    <= '0;
      t_cnt     <= '0;
      k_cnt     <= '0;
      o_overrun <= 1'b0;
    end else begin
      ff_prev <= i_first_finish;

      if (trigger && state != IDLE) o_overrun <= 1'b1;
      else if (i_clear_overrun)     o_overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (trigger) begin
            n_last <= n_last_next;
            k_cnt  <= '0;
            if (n_last_next == '0) begin
              t_cnt <= '0;
              state <= DRAIN;
            end else begin
              t_cnt <= IDX_BITS'(1);
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (t_cnt == n_last) begin
            t_cnt <= '0;
            k_cnt <= '0;
            state <= DRAIN;
          end else begin
            t_cnt <= t_cnt + IDX_BITS'(1);
          end
        end
        DRAIN: begin
          if (i_tready) begin
            if (k_cnt == n_last) begin
              k_cnt <= '0;
              if (t_cnt == n_last) begin
                t_cnt <= '0;
                state <= IDLE;
              end else begin
                t_cnt <= t_cnt + IDX_BITS'(1);
              end
            end else begin
              k_cnt <= k_cnt + IDX_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - directed, table-driven bench for the result collector.
module tb_systolic_result_collector;
  localparam int SIZE = 4;
  localparam int O_BITS = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [2:0]             rf;
  logic                   ff;
  logic [SIZE*O_BITS-1:0] c_diag;
  logic [O_BITS-1:0]      tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [3:0]             tuser;
  logic                   busy;
  logic                   ovr;
  logic                   clr;

  always #5 clk = ~clk;

  systolic_result_collector #(.SIZE(SIZE), .O_BITS(O_BITS)) dut (
    .i_clock(clk), .i_reset(rst), .rf_matrix_size(rf), .i_first_finish(ff),
    .i_c_diag(c_diag), .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready),
    .o_tlast(tlast), .o_tuser(tuser), .o_busy(busy), .o_overrun(ovr),
    .i_clear_overrun(clr)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  user;
    logic        last;
  } beat_t;

  beat_t       got[$];
  beat_t       exp_tab[4];
  logic [15:0] vec [4][4];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SIZE*O_BITS-1:0] word(input int t);
    logic [SIZE*O_BITS-1:0] w;
    for (int l = 0; l < SIZE; l++) w[l*O_BITS +: O_BITS] = vec[t][l];
    return w;
  endfunction

  // Trigger, feed n capture vectors on consecutive cycles, check first-valid latency.
  task automatic capture(input int rfv, input int n, input bit hold);
    rf = 3'(rfv);
    ff = 1'b1;
    c_diag = word(0);
    tick;
    if (!hold) ff = 1'b0;
    rf = ~rf;
    chk("busy_after_trigger", busy, 1);
    for (int t = 1; t < n; t++) begin
      chk("no_early_valid", tvalid, 0);
      c_diag = word(t);
      tick;
    end
    c_diag = '1;
    chk("valid_latency", tvalid, 1);
  endtask

  // Collect n*n beats; optional stall pattern and an extra first_finish pulse at a beat index.
  task automatic drain(input int n, input bit stall, input int ovr_beat);
    int    cyc;
    bit    pat[6];
    bit    was_stalled;
    beat_t prev;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    cyc = 0;
    was_stalled = 1'b0;
    got.delete();
    while (got.size() < n*n && cyc < 300) begin
      tready = stall ? pat[cyc % 6] : 1'b1;
      if (ovr_beat >= 0) ff = (got.size() == ovr_beat);
      if (tvalid) begin
        if (was_stalled) begin
          chk("hold_tdata", tdata, prev.data);
          chk("hold_tuser", tuser, prev.user);
          chk("hold_tlast", tlast, prev.last);
        end
        prev = '{tdata, tuser, tlast};
        was_stalled = !tready;
        if (tready) got.push_back(prev);
      end
      tick;
      cyc++;
    end
    if (ovr_beat >= 0) ff = 1'b0;
    tready = 1'b0;
    chk("beat_count", got.size(), n*n);
    chk("valid_drop_after_last", tvalid, 0);
    chk("idle_after_last", busy, 0);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        chk({tag, "_tdata"}, got[i].data, exp_tab[i].data);
        chk({tag, "_tuser"}, got[i].user, exp_tab[i].user);
        chk({tag, "_tlast"}, got[i].last, exp_tab[i].last);
      end
    end
  endtask

  task automatic check_model(input int n);
    for (int b = 0; b < n*n && b < got.size(); b++) begin
      int t = b / n;
      int k = b % n;
      chk("n4_tdata", got[b].data, vec[t][k]);
      chk("n4_tuser", got[b].user, {2'(k), 2'(t)});
      chk("n4_tlast", got[b].last, (b == n*n-1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int t = 0; t < 4; t++)
      for (int l = 0; l < 4; l++)
        vec[t][l] = 16'(t*4 + l + 1);
    exp_tab[0] = '{16'd1, 4'b0000, 1'b0};
    exp_tab[1] = '{16'd2, 4'b0100, 1'b0};
    exp_tab[2] = '{16'd5, 4'b0001, 1'b0};
    exp_tab[3] = '{16'd6, 4'b0101, 1'b1};

    rst = 1'b1; ff = 1'b1; rf = 3'd1; c_diag = word(0); tready = 1'b0; clr = 1'b0;
    tick;
    tick;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", ovr, 0);

    // first_finish already high when reset releases: history is 0, so it triggers.
    rst = 1'b0;
    capture(1, 2, 0);
    drain(2, 0, -1);
    check_table("n2");

    capture(1, 2, 0);
    drain(2, 1, -1);
    check_table("n2_stall");

    vec[0][0] = 16'hABCD;
    capture(0, 1, 0);
    drain(1, 0, -1);
    if (got.size() > 0) begin
      chk("n1_tdata", got[0].data, 16'hABCD);
      chk("n1_tuser", got[0].user, 0);
      chk("n1_tlast", got[0].last, 1);
    end
    vec[0][0] = 16'd1;

    capture(7, 4, 0);
    drain(4, 0, -1);
    check_model(4);

    capture(1, 2, 0);
    drain(2, 0, 1);
    check_table("ovr_mid");
    chk("overrun_set", ovr, 1);
    tick;
    chk("overrun_sticky", ovr, 1);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("overrun_cleared", ovr, 0);

    capture(1, 2, 0);
    drain(2, 0, 3);
    check_table("ovr_last");
    chk("overrun_on_last", ovr, 1);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("overrun_cleared2", ovr, 0);

    capture(1, 2, 1);
    drain(2, 0, -1);
    check_table("hold");
    for (int i = 0; i < 6; i++) tick;
    chk("hold_single_busy", busy, 0);
    chk("hold_no_overrun", ovr, 0);
    ff = 1'b0;
    tick;

    capture(1, 2, 0);
    tready = 1'b1;
    tick;
    tick;
    chk("pre_reset_beat", tuser, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tvalid", tvalid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tlast", tlast, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tready = 1'b0;
    tick;
    capture(1, 2, 0);
    drain(2, 0, -1);
    check_table("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
